// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the fetch port (IF)
//               and the data port (MEM, lw/sw) of a 5-stage CPU. Serves one
//               access at a time and owns every memory strobe. Read data comes
//               back with a one-cycle done pulse, and per-port stalls hold the
//               pipeline until its access completes.
//               Optional feature macro: MEM_ARB_FAIRNESS_EN (forces a waiting
//               fetch after STARVE_MAX consecutive data grants).
// Ports       : clock, reset_n              - clock / async active-low reset
//               if_req/if_addr/if_flush     - fetch request, PC, flush
//               if_done/if_rdata/if_stall   - fetch completion, data, stall
//               dm_req/dm_we/dm_addr/dm_wdata - data request (load/store)
//               dm_done/dm_rdata/dm_stall   - data completion, data, stall
//               mem_addr/mem_wdata/mem_rd/mem_wr/mem_rdata - memory side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The WAIT counter runs from MEM_LAT-1 down to 0, so the capture cycle is
  // exactly MEM_LAT cycles after the strobe cycle.
  localparam int                CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  LAT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;   // 1 = data port owns access
  logic                we_q, we_d;
  logic                flushed_q, flushed_d;     // fetch in flight was flushed
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic if_cand;
  logic force_if;
  logic grant_dm;
  logic grant_if;

  // A flush in the arbitration cycle removes the fetch from contention.
  assign if_cand  = if_req & ~if_flush;
  assign grant_dm = (state_q == S_IDLE) & dm_req & ~force_if;
  assign grant_if = (state_q == S_IDLE) & if_cand & ~grant_dm;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = if_cand & (starve_cnt_q == STARVE_LIM);

  // Counts data grants made while a fetch is waiting; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req) begin
      starve_cnt_d = '0;
    end else if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_dm && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict data priority: the fetch is never forced.
  assign force_if = (STARVE_MAX < 0);
`endif

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    flushed_d   = flushed_q;
    lat_cnt_d   = lat_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Strobes are registered: deciding here puts them in the ISSUE cycle.
        if (grant_dm) begin
          owner_dm_d  = 1'b1;
          we_d        = dm_we;
          flushed_d   = 1'b0;
          mem_addr_d  = dm_addr & ALIGN_MASK;
          mem_wdata_d = dm_wdata;
          mem_rd_d    = ~dm_we;
          mem_wr_d    = dm_we;
          state_d     = S_ISSUE;
        end else if (grant_if) begin
          owner_dm_d  = 1'b0;
          we_d        = 1'b0;
          flushed_d   = 1'b0;
          mem_addr_d  = if_addr & ALIGN_MASK;
          mem_rd_d    = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        lat_cnt_d = LAT_INIT;
        if (!owner_dm_q && if_flush) begin
          flushed_d = 1'b1;
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!owner_dm_q && if_flush) begin
          flushed_d = 1'b1;
        end
        if (lat_cnt_q == '0) begin
          state_d = S_IDLE;
          if (owner_dm_q) begin
            dm_done_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else if (!(flushed_q || if_flush)) begin
            // A flushed fetch still completes on the memory but is dropped.
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      flushed_q   <= 1'b0;
      lat_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      flushed_q   <= flushed_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Stalls are combinational so the pipeline releases in the done cycle.
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (MEM_LAT = 3) with a
//               behavioural memory and a transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 4;
  localparam int P    = LAT + 2;   // one access: request cycle to done cycle

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Cycle index: cycle k lies between posedge k and posedge k+1.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memory: read data appears LAT cycles after the strobe cycle;
  // any other cycle carries junk so a mistimed capture is visible.
  logic [31:0] devmem [0:255];
  logic [31:0] resp_data [int];
  always @(negedge clock) begin
    if (mem_wr) devmem[mem_addr[9:2]] = mem_wdata;
    if (mem_rd) resp_data[cyc + LAT] = devmem[mem_addr[9:2]];
    if (resp_data.exists(cyc)) begin
      mem_rdata = resp_data[cyc];
      resp_data.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic test_reset();
    logic [133:0] snap;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    snap = {mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall,
            mem_addr, mem_wdata, if_rdata, dm_rdata};
    tests_run++;
    if (snap !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h required 0", snap);
    end
    @(negedge clock) reset_n = 1'b1;

    // Complete one load so dm_rdata is non-zero before the abandoned one.
    devmem[8] = 32'hA5A5_0001;
    @(negedge clock);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    for (int c = 0; c <= P; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      tests_run++;
      if (dm_done !== (c == P)) begin
        tests_failed++;
        $display("FAIL reset_preload_done c=%0d: got %b required %b", c, dm_done, (c == P));
      end
      if (c == P) begin
        exp_dm_rdata = 32'hA5A5_0001;
        tests_run++;
        if (dm_rdata !== exp_dm_rdata) begin
          tests_failed++;
          $display("FAIL reset_preload_rdata: got %h required %h", dm_rdata, exp_dm_rdata);
        end
        dm_req = 1'b0;
      end
    end

    // Second load, reset asserted in the middle of WAIT.
    @(negedge clock);
    dm_req = 1'b1; dm_addr = 32'h24;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    dm_req = 1'b0;
    #1;
    snap = {mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall,
            mem_addr, mem_wdata, if_rdata, dm_rdata};
    exp_dm_rdata = '0;
    exp_if_rdata = '0;
    tests_run++;
    if (snap !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: got %h required 0", snap);
    end
    @(negedge clock) reset_n = 1'b1;
    for (int c = 0; c <= P + 1; c++) begin
      @(negedge clock);
      #1;
      tests_run++;
      if ({dm_done, if_done, mem_rd, mem_wr} !== 4'b0 || dm_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_abandoned c=%0d: got done/strobes %b rdata %h required 0",
                 c, {dm_done, if_done, mem_rd, mem_wr}, dm_rdata);
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [31:0] w;
    w = $urandom;
    devmem[16] = w;
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c <= P; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      tests_run++;
      if (mem_rd !== (c == 1) || mem_wr !== 1'b0) begin
        tests_failed++;
        $display("FAIL fetch_strobe c=%0d: got rd %b wr %b required rd %b", c, mem_rd, mem_wr, (c == 1));
      end
      if (c == 1) begin
        tests_run++;
        if (mem_addr !== 32'h40) begin
          tests_failed++;
          $display("FAIL fetch_addr: got %h required 00000040", mem_addr);
        end
      end
      tests_run++;
      if (if_done !== (c == P) || if_stall !== (c < P)) begin
        tests_failed++;
        $display("FAIL fetch_done_stall c=%0d: got done %b stall %b required %b %b",
                 c, if_done, if_stall, (c == P), (c < P));
      end
      if (c == P) begin
        exp_if_rdata = w;
        tests_run++;
        if (if_rdata !== exp_if_rdata) begin
          tests_failed++;
          $display("FAIL fetch_rdata: got %h required %h", if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_priority();
    logic [31:0] wd, wi;
    wd = $urandom; wi = $urandom;
    devmem[32] = wd;   // 0x80
    devmem[17] = wi;   // 0x44
    @(negedge clock);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h44;
    for (int c = 0; c <= 2 * P; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      tests_run++;
      if (mem_rd !== (c == 1 || c == P + 1)) begin
        tests_failed++;
        $display("FAIL prio_strobe c=%0d: got %b required %b", c, mem_rd, (c == 1 || c == P + 1));
      end
      if (c == 1 || c == P + 1) begin
        tests_run++;
        if (mem_addr !== ((c == 1) ? 32'h80 : 32'h44)) begin
          tests_failed++;
          $display("FAIL prio_addr c=%0d: got %h required %h", c, mem_addr, ((c == 1) ? 32'h80 : 32'h44));
        end
      end
      tests_run++;
      if (dm_done !== (c == P) || if_done !== (c == 2 * P)) begin
        tests_failed++;
        $display("FAIL prio_done c=%0d: got dm %b if %b required %b %b",
                 c, dm_done, if_done, (c == P), (c == 2 * P));
      end
      if (c == P) begin
        exp_dm_rdata = wd;
        tests_run++;
        if (dm_rdata !== exp_dm_rdata || if_rdata !== exp_if_rdata) begin
          tests_failed++;
          $display("FAIL prio_dm_rdata: got %h/%h required %h/%h", dm_rdata, if_rdata, exp_dm_rdata, exp_if_rdata);
        end
        dm_req = 1'b0;
      end
      if (c == 2 * P) begin
        exp_if_rdata = wi;
        tests_run++;
        if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
          tests_failed++;
          $display("FAIL prio_if_rdata: got %h/%h required %h/%h", if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    @(negedge clock);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h103; dm_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= P; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      tests_run++;
      if (mem_wr !== (c == 1) || mem_rd !== 1'b0) begin
        tests_failed++;
        $display("FAIL store_strobe c=%0d: got wr %b rd %b required wr %b rd 0", c, mem_wr, mem_rd, (c == 1));
      end
      if (c == 1) begin
        tests_run++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("FAIL store_addr_data: got %h/%h required 00000100/deadbeef", mem_addr, mem_wdata);
        end
      end
      tests_run++;
      if (dm_done !== (c == P)) begin
        tests_failed++;
        $display("FAIL store_done c=%0d: got %b required %b", c, dm_done, (c == P));
      end
      if (c == P) begin
        tests_run++;
        if (dm_rdata !== exp_dm_rdata) begin
          tests_failed++;
          $display("FAIL store_rdata_kept: got %h required %h", dm_rdata, exp_dm_rdata);
        end
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
    tests_run++;
    if (devmem[64] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL store_memory: got %h required deadbeef", devmem[64]);
    end
  endtask

  task automatic test_flush();
    logic [31:0] wa, wb;
    wa = $urandom; wb = $urandom ^ 32'h5A5A_5A5A;
    devmem[18] = wa;   // 0x48
    devmem[19] = wb;   // 0x4C
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h48;
    for (int c = 0; c <= 2 * P; c++) begin
      if (c > 0) @(negedge clock);
      if_flush = (c == 2);
      #1;
      tests_run++;
      if (mem_rd !== (c == 1 || c == P + 1)) begin
        tests_failed++;
        $display("FAIL flush_strobe c=%0d: got %b required %b", c, mem_rd, (c == 1 || c == P + 1));
      end
      tests_run++;
      if (if_done !== (c == 2 * P)) begin
        tests_failed++;
        $display("FAIL flush_done c=%0d: got %b required %b", c, if_done, (c == 2 * P));
      end
      if (c == P) begin
        tests_run++;
        if (if_rdata !== exp_if_rdata || if_stall !== 1'b1) begin
          tests_failed++;
          $display("FAIL flush_kept: got rdata %h stall %b required %h 1", if_rdata, if_stall, exp_if_rdata);
        end
        if_addr = 32'h4C;   // held request becomes the refetch
      end
      if (c == P + 1) begin
        tests_run++;
        if (mem_addr !== 32'h4C) begin
          tests_failed++;
          $display("FAIL flush_refetch_addr: got %h required 0000004c", mem_addr);
        end
      end
      if (c == 2 * P) begin
        exp_if_rdata = wb;
        tests_run++;
        if (if_rdata !== exp_if_rdata) begin
          tests_failed++;
          $display("FAIL flush_refetch_rdata: got %h required %h", if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    int nd, fetch_pos, fetch_cyc, exp_pos;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_pos = SMAX;
`else
    exp_pos = 6;
`endif
    nd = 0; fetch_pos = -1; fetch_cyc = -1;
    @(negedge clock);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h14;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      if (dm_done) begin
        nd++;
        exp_dm_rdata = devmem[4];
        if (nd == 6) dm_req = 1'b0;
      end
      if (if_done) begin
        fetch_pos = nd;
        fetch_cyc = c;
        exp_if_rdata = devmem[5];
        if_req = 1'b0;
        dm_req = 1'b0;
        break;
      end
    end
    tests_run++;
    if (fetch_pos !== exp_pos) begin
      tests_failed++;
      $display("FAIL starve_order: fetch after %0d data accesses, required %0d", fetch_pos, exp_pos);
    end
    tests_run++;
    if (fetch_cyc !== (exp_pos + 1) * P) begin
      tests_failed++;
      $display("FAIL starve_fetch_cycle: got %0d required %0d", fetch_cyc, (exp_pos + 1) * P);
    end
    repeat (2) @(negedge clock);
  endtask

  // Random traffic against a slot-based model: whenever the arbiter is free,
  // the pending data request wins unless the fairness limit forces the fetch;
  // each grant strobes one cycle later and completes LAT+2 cycles later.
  task automatic test_random();
    int if_done_at, dm_done_at, strobe_at, free_at, starve;
    logic strobe_we, force_m, granted;
    logic [31:0] strobe_addr, strobe_wdata, dm_exp, if_exp;
    logic if_act, dm_act, dm_we_m;
    logic [31:0] if_a, dm_a, dm_wd;
    logic [31:0] ref_mem [0:255];
    if_done_at = -1; dm_done_at = -1; strobe_at = -1; free_at = 0; starve = 0;
    strobe_we = 1'b0; strobe_addr = '0; strobe_wdata = '0; dm_exp = '0; if_exp = '0;
    if_act = 1'b0; dm_act = 1'b0; dm_we_m = 1'b0; if_a = '0; dm_a = '0; dm_wd = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = devmem[i];
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      #1;
      tests_run++;
      if (if_done !== (k == if_done_at) || dm_done !== (k == dm_done_at)) begin
        tests_failed++;
        $display("FAIL rand_done k=%0d: got if %b dm %b required %b %b",
                 k, if_done, dm_done, (k == if_done_at), (k == dm_done_at));
      end
      if (k == if_done_at) begin exp_if_rdata = if_exp; if_act = 1'b0; end
      if (k == dm_done_at) begin
        if (!dm_we_m) exp_dm_rdata = dm_exp;
        dm_act = 1'b0;
      end
      tests_run++;
      if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
        tests_failed++;
        $display("FAIL rand_rdata k=%0d: got %h/%h required %h/%h",
                 k, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
      end
      tests_run++;
      if (mem_rd !== (k == strobe_at && !strobe_we) || mem_wr !== (k == strobe_at && strobe_we)) begin
        tests_failed++;
        $display("FAIL rand_strobe k=%0d: got rd %b wr %b required %b %b", k, mem_rd, mem_wr,
                 (k == strobe_at && !strobe_we), (k == strobe_at && strobe_we));
      end
      if (k == strobe_at) begin
        tests_run++;
        if (mem_addr !== strobe_addr || (strobe_we && mem_wdata !== strobe_wdata)) begin
          tests_failed++;
          $display("FAIL rand_addr k=%0d: got %h/%h required %h/%h", k, mem_addr, mem_wdata,
                   strobe_addr, strobe_wdata);
        end
      end
      // New requests (none near the end so everything drains).
      if (k < 380 && !dm_act && ($urandom % 3 == 0)) begin
        dm_act = 1'b1; dm_we_m = 1'($urandom);
        dm_a = {22'd0, 8'($urandom), 2'($urandom)}; dm_wd = $urandom;
      end
      if (k < 380 && !if_act && ($urandom % 3 == 0)) begin
        if_act = 1'b1;
        if_a = {22'd0, 8'($urandom), 2'($urandom)};
      end
      dm_req = dm_act; dm_we = dm_we_m; dm_addr = dm_a; dm_wdata = dm_wd;
      if_req = if_act; if_addr = if_a;
      if (!if_act) starve = 0;
      if (k >= free_at) begin
`ifdef MEM_ARB_FAIRNESS_EN
        force_m = if_act && (starve == SMAX);
`else
        force_m = 1'b0;
`endif
        granted = 1'b0;
        if (dm_act && !force_m) begin
          granted = 1'b1;
          strobe_we = dm_we_m; strobe_addr = dm_a & ~32'd3; strobe_wdata = dm_wd;
          if (dm_we_m) ref_mem[dm_a[9:2]] = dm_wd;
          else dm_exp = ref_mem[dm_a[9:2]];
          dm_done_at = k + LAT + 2;
          if (if_act && starve < SMAX) starve++;
        end else if (if_act) begin
          granted = 1'b1;
          strobe_we = 1'b0; strobe_addr = if_a & ~32'd3;
          if_exp = ref_mem[if_a[9:2]];
          if_done_at = k + LAT + 2;
          starve = 0;
        end
        if (granted) begin
          strobe_at = k + 1;
          free_at = k + LAT + 2;
        end
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) devmem[i] = $urandom;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_flush();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
